if_stage: RTL and testbench

Instruction fetch stage of the five-stage pipelined core. It keeps the program counter and issues one word fetch at a time to instruction memory. Each returned word is registered together with its PC and offered to the decode stage through a valid/ack handshake. A redirect from the execute stage changes the fetch address and discards any wrong-path instruction, whether it is buffered or still in flight.

---
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: keeps the PC, issues one word fetch at a time and registers the returned word with its PC for decode.
// Latency: a word reaches valid_o the cycle after mem_ack_i, so throughput is one instruction every L+1 cycles for memory latency L.
// Backpressure: while valid_o=1 and ack_i=0 the output slot holds steady and no fetch is issued; a redirect squashes the slot and any in-flight fetch.
//
// Ports:
//   clk, rstn_i                 clock, asynchronous active-low reset
//   mem_req_o, mem_addr_o       single-cycle fetch request and its word address
//   mem_ack_i, mem_rdata_i      single-cycle response pulse and the fetched word
//   valid_o, instr_o, pc_o      instruction slot offered to decode
//   ack_i                       decode consumed the slot this cycle
//   branch_i, branch_target_i   redirect from execute (target low bits ignored)
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        ack_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i
);

    // Word alignment: the two low address bits never reach the PC.
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    // REQ : idle, may issue a fetch at pc_q
    // WAIT: right-path fetch outstanding, its word goes to decode
    // DROP: wrong-path fetch outstanding, its word is thrown away
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;

    logic        slot_free;
    logic        issue;
    logic        fill;

    // The slot can take a new word if it is empty or being consumed now.
    assign slot_free = !valid_o || ack_i;

    // rstn_i is folded in so the request line stays low while reset is held,
    // even though the FSM already sits in REQ with an empty slot.
    assign issue = rstn_i && (state_q == S_REQ) && slot_free && !branch_i;

    // A right-path response lands in the slot unless a redirect kills it
    // in the same cycle.
    assign fill = (state_q == S_WAIT) && mem_ack_i && !branch_i;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response always retires the outstanding fetch, whether
                // it is kept or squashed by a simultaneous redirect.
                if (mem_ack_i) begin
                    state_d = S_REQ;
                end else if (branch_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (mem_ack_i) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_req_o  = 1'b0;
        mem_addr_o = 32'h0000_0000;
        if (issue) begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Program counter
    // ------------------------------------------------------------------
    // pc_q is the address of the next word decode should see. It only
    // advances when that word is actually captured, so a dropped wrong-path
    // response leaves it pointing at the redirect target.
    always_comb begin
        pc_d = pc_q;
        if (branch_i) begin
            pc_d = branch_target_i & ALIGN_MASK;
        end else if (fill) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            pc_q <= RESET_PC_ALIGNED;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // Output slot
    // ------------------------------------------------------------------
    // A redirect empties the slot even if decode acks in the same cycle.
    // instr_o/pc_o only change on a fill, so they hold under backpressure.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o <= 1'b0;
            instr_o <= 32'h0000_0000;
            pc_o    <= 32'h0000_0000;
        end else begin
            if (branch_i) begin
                valid_o <= 1'b0;
            end else if (fill) begin
                valid_o <= 1'b1;
                instr_o <= mem_rdata_i;
                pc_o    <= pc_q;
            end else if (ack_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        rstn_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        ack_i;
    logic        branch_i;
    logic [31:0] branch_target_i;

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rstn_i          (rstn_i),
        .mem_req_o       (mem_req_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .valid_o         (valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .ack_i           (ack_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the address of the next instruction decode must see,
    // what the slot should hold, and whether a fetch is outstanding / doomed.
    logic [31:0] next_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    bit          exp_valid;
    bit          busy;
    bit          dropping;
    int          n_deliv;

    // Memory model: one pending fetch, answered after a random latency.
    bit          mem_pend;
    bit          mem_hold;
    logic [31:0] mem_a;
    int          mem_cnt;
    int          lat_min;
    int          lat_max;

    // Values sampled in the most recent cycle.
    bit          s_req;
    bit          s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;

    function automatic logic [31:0] word_of(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are already driven (at the falling edge);
    // outputs are checked 1ns later, then the model steps at the rising edge.
    task automatic tick();
        bit issue_ok;
        bit deliver;
        if (mem_pend && mem_cnt == 0 && !mem_hold) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = word_of(mem_a);
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
        end
        #1;
        s_req   = mem_req_o;
        s_addr  = mem_addr_o;
        s_valid = valid_o;
        s_pc    = pc_o;
        if (rstn_i) begin
            chk("valid_o", valid_o, exp_valid);
            if (exp_valid) begin
                chk("pc_o", pc_o, exp_pc);
                chk("instr_o", instr_o, exp_instr);
            end
            issue_ok = (!exp_valid || ack_i) && !branch_i && !busy;
            chk("mem_req_o", mem_req_o, issue_ok);
            if (mem_req_o) chk("mem_addr_o", mem_addr_o, next_pc);
        end else begin
            chk("rst_valid_o", valid_o, 0);
            chk("rst_mem_req_o", mem_req_o, 0);
            chk("rst_mem_addr_o", mem_addr_o, 0);
            chk("rst_pc_o", pc_o, 0);
            chk("rst_instr_o", instr_o, 0);
        end
        @(posedge clk);
        if (!rstn_i) begin
            exp_valid = 0;
            next_pc   = RST_PC;
            busy      = 0;
            dropping  = 0;
        end else begin
            deliver = busy && mem_ack_i && !dropping && !branch_i;
            if (busy && mem_ack_i) begin
                busy     = 0;
                dropping = 0;
            end
            if (branch_i) begin
                if (busy) dropping = 1;
                exp_valid = 0;
                next_pc   = branch_target_i & 32'hFFFF_FFFC;
            end else if (deliver) begin
                exp_valid = 1;
                exp_pc    = next_pc;
                exp_instr = word_of(next_pc);
                next_pc   = next_pc + 32'd4;
                n_deliv++;
            end else if (ack_i) begin
                exp_valid = 0;
            end
            if (s_req) busy = 1;
        end
        if (mem_ack_i) mem_pend = 0;
        else if (mem_pend && !mem_hold && mem_cnt > 0) mem_cnt--;
        if (s_req) begin
            mem_pend = 1;
            mem_a    = s_addr;
            mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(negedge clk);
    endtask

    // Run until a request goes out (bounded); report its address and how
    // many cycles on the way showed valid_o.
    task automatic wait_req(output bit got, output logic [31:0] addr, output int nvalid);
        got    = 0;
        addr   = 32'h0;
        nvalid = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (s_valid) nvalid++;
            if (s_req) begin
                got  = 1;
                addr = s_addr;
            end
        end
    endtask

    task automatic wait_valid(output bit got);
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            tick();
            if (s_valid) got = 1;
        end
    endtask

    initial begin
        bit          got;
        logic [31:0] addr;
        int          nvalid;
        int          nreq;
        logic [31:0] held_pc;

        rstn_i = 0; ack_i = 1; branch_i = 0; branch_target_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
        exp_valid = 0; busy = 0; dropping = 0; next_pc = RST_PC;
        exp_pc = 0; exp_instr = 0; n_deliv = 0;
        mem_pend = 0; mem_hold = 0; mem_a = 0; mem_cnt = 0;
        lat_min = 1; lat_max = 1;
        @(negedge clk);

        // Reset state, then latency 1 with decode always accepting.
        for (int i = 0; i < 3; i++) tick();
        rstn_i = 1;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (s_req) nreq++;
        end
        chk("rate_lat1_reqs_in_20", nreq, 10);
        chk("rate_lat1_deliveries", n_deliv, 10);

        // Backpressure: slot held for 5 cycles, then request on the ack cycle.
        ack_i = 0;
        wait_valid(got);
        chk("bp_valid_seen", got, 1);
        held_pc = s_pc;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_pc_stable", s_pc, held_pc);
            chk("bp_no_req", s_req, 0);
        end
        ack_i = 1;
        tick();
        chk("bp_req_on_ack", s_req, 1);

        // Redirect to 0x200 while a fetch is in flight (latency 4).
        lat_min = 4; lat_max = 4;
        wait_req(got, addr, nvalid);
        branch_i = 1; branch_target_i = 32'h0000_0200;
        tick();
        branch_i = 0;
        wait_req(got, addr, nvalid);
        chk("br_wait_got_req", got, 1);
        chk("br_wait_addr", addr, 32'h0000_0200);
        chk("br_wait_no_valid", nvalid, 0);

        // Redirect to 0x40 in the same cycle as the response (latency 3).
        lat_min = 3; lat_max = 3;
        wait_req(got, addr, nvalid);
        tick();
        tick();
        branch_i = 1; branch_target_i = 32'h0000_0040;
        tick();
        branch_i = 0;
        tick();
        chk("br_ack_valid_next", s_valid, 0);
        chk("br_ack_req", s_req, 1);
        chk("br_ack_addr", s_addr, 32'h0000_0040);

        // Redirect to 0x203 while decode acks a valid slot.
        lat_min = 1; lat_max = 1;
        ack_i = 0;
        wait_valid(got);
        chk("br_slot_valid_seen", got, 1);
        ack_i = 1; branch_i = 1; branch_target_i = 32'h0000_0203;
        tick();
        branch_i = 0;
        tick();
        chk("br_slot_valid_next", s_valid, 0);
        chk("br_slot_req", s_req, 1);
        chk("br_slot_addr", s_addr, 32'h0000_0200);

        // PC wraps from FFFF_FFFC to 0.
        lat_min = 2; lat_max = 2;
        branch_i = 1; branch_target_i = 32'hFFFF_FFF8;
        tick();
        branch_i = 0;
        wait_req(got, addr, nvalid);
        chk("wrap_addr_fff8", addr, 32'hFFFF_FFF8);
        wait_req(got, addr, nvalid);
        chk("wrap_addr_fffc", addr, 32'hFFFF_FFFC);
        wait_req(got, addr, nvalid);
        chk("wrap_addr_0", addr, 32'h0000_0000);

        // Reset while waiting; the stale response lands right after release.
        lat_min = 6; lat_max = 6;
        wait_req(got, addr, nvalid);
        tick();
        rstn_i = 0; mem_hold = 1;
        for (int i = 0; i < 3; i++) tick();
        rstn_i = 1; mem_hold = 0; mem_cnt = 0;
        lat_min = 1; lat_max = 1;
        tick();
        chk("rst_late_req", s_req, 1);
        chk("rst_late_addr", s_addr, RST_PC);
        for (int i = 0; i < 6; i++) tick();

        // Randomized traffic: latency, decode stalls and redirects.
        lat_min = 1; lat_max = 4;
        n_deliv = 0;
        for (int i = 0; i < 4000; i++) begin
            ack_i    = ($urandom_range(3, 0) != 0);
            branch_i = ($urandom_range(15, 0) == 0);
            if ($urandom_range(7, 0) == 0) branch_target_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else branch_target_i = $urandom;
            tick();
        end
        branch_i = 0;
        chk("rand_progress", (n_deliv > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
